data_io_sync: RTL
=================

Name: data_io_sync

Overview:
- Next-generation ARM-to-FPGA SPI link for MiST/Multicore cores; replaces the SCK-clocked I/O block.
- Samples SPI_SCK/SPI_SS2/SPI_DI entirely in the clk_sys domain, so it has a single clock and no SPI-clock flops.
- Decodes the command set: ACK, data read, config string, status, file index, data pump.
- Download stream is packed into DW-bit words and buffered in a FIFO, honouring ioctl_wait backpressure without losing bytes.

Parameters:
- STRLEN, 0: config string length in bytes.
- DW, 8: ioctl_dout width; 8, 16 or 32, always a multiple of 8.
- AW, 25: ioctl_addr width; byte address.
- FIFO_DEPTH, 4: download words buffered; power of 2, at least 2.
- STATUS_BYTES, 4: bytes in the status word (1..8).

Ports:
- clk_sys  in  1  system clock; SPI_SCK must be at most clk_sys/8.
- reset  in  1  synchronous, active-high.
- SPI_SCK  in  1  asynchronous; 3-flop synchronised.
- SPI_SS2  in  1  active-low select; asynchronous; 3-flop synchronised.
- SPI_DI  in  1  MOSI; asynchronous; 3-flop synchronised.
- SPI_DO  out  1  MISO; 1'bZ while deselected.
- data_in  in  8  byte returned by command 0x10.
- conf_str  in  8*STRLEN  config string, first character in the MSBs.
- status  out  8*STATUS_BYTES  menu status word.
- ioctl_wait  in  1  sink stall.
- ioctl_download  out  1  download active.
- ioctl_index  out  8  file/menu index.
- ioctl_wr  out  1  one-cycle write strobe.
- ioctl_addr  out  AW  byte address of the word's first byte.
- ioctl_dout  out  DW  packed data, first byte in bits [7:0].
- ioctl_overflow  out  1  sticky: a word was dropped because the FIFO was full.

Behaviour:
- Reset: status=0, ioctl_index=0, ioctl_download=0, ioctl_wr=0, ioctl_addr=0, ioctl_dout=0, ioctl_overflow=0. FIFO is emptied and the SPI engine goes to IDLE. Reset mid-download discards all buffered data.
- SPI engine, mode 0:
  - Synchronised SS2 high forces IDLE: bit count 0, byte count 0, SPI_DO=Z.
  - A synchronised SCK rising edge shifts SPI_DI in, MSB first.
  - A synchronised SCK falling edge drives the next output bit onto SPI_DO.
  - SPI_DO holds MSB of the reply byte from SS2 fall until the first falling edge.
- Frame structure: byte 0 = command; later bytes = payload, counted by byte_cnt starting at 0.
- Commands:
  - 0x00: reply 0x4B on every payload byte.
  - 0x10: reply data_in; data_in is sampled at the start of each reply byte.
  - 0x14: payload byte k returns conf_str[8*(STRLEN-k)-1 -: 8] for k<STRLEN, else 0x00.
  - 0x15: payload bytes load status MSB byte first; bytes beyond STATUS_BYTES are ignored. status updates only when a complete byte is received.
  - 0x55: each payload byte loads ioctl_index.
  - 0x61:
    - If ioctl_download was 0: set it, clear packing state, clear ioctl_overflow, set the next address to 0.
    - Each payload byte goes into the packer. Every DW/8 bytes the word is pushed to the FIFO with its start address; the address then advances by DW/8.
  - 0x62: a partial word is zero-padded and pushed. After that, ioctl_download falls the cycle after the FIFO is empty and the last ioctl_wr has issued.
  - Unknown commands: reply 0x00; payload ignored.
- FIFO:
  - Pop when not empty and ioctl_wait=0. The popped entry appears on ioctl_addr/ioctl_dout with ioctl_wr=1 for exactly that cycle.
  - Push to pop latency is 1 clk_sys.
  - Simultaneous push and pop at full is allowed.
  - Push while full and not popping: word dropped, ioctl_overflow=1, address still advances.
- Abandoned byte: SS2 rising mid-byte discards the partial byte. Packing state survives SS2 toggles, so one download may span several frames.
- ioctl_wr is never asserted while ioctl_download=0.

Optional Feature:
- DATA_IO_CRC_EN defined:
  - Adds output ioctl_crc[15:0].
  - CRC-16/CCITT (poly 0x1021, init 0xFFFF, MSB first) over every payload byte of 0x61, pad bytes excluded.
  - Initialised when a download starts; stable once ioctl_download falls.
  - Command 0x63 replies with the CRC, MSB byte first.
- Without the macro: no port, no CRC logic, and 0x63 is treated as an unknown command.

Decomposition:
- Package data_io_pkg holds:
  - command localparams CMD_ACK=8'h00, CMD_READ=8'h10, CMD_CONF=8'h14, CMD_STATUS=8'h15, CMD_INDEX=8'h55, CMD_PUMP=8'h61, CMD_PUMP_END=8'h62, CMD_CRC=8'h63;
  - ACK_BYTE=8'h4B;
  - SPI engine state enum IDLE/CMD/PAYLOAD.
- Sub-module data_io_fifo: synchronous FIFO of width AW+DW and depth FIFO_DEPTH, with full/empty and pointer wrap.

Test Plan:
- Cmd 0x00, 2 payload bytes -> MISO reads 0x4B, 0x4B; SPI_DO=Z after SS2 rises.
- STRLEN=3, conf_str="AB;", cmd 0x14, 5 payload bytes -> 0x41, 0x42, 0x3B, 0x00, 0x00.
- Cmd 0x15 then 0x12 0x34 0x56 0x78 0x9A -> status=32'h12345678; the extra byte is ignored.
- DW=16, cmd 0x61 with 0x11 0x22 0x33, then cmd 0x62 -> writes (addr 0, 0x2211) and (addr 2, 0x0033); ioctl_download falls after the second write.
- FIFO_DEPTH=2, ioctl_wait held high, 4 words pumped -> 2 words written after release; ioctl_overflow=1; addresses 0 and 1 for DW=8.
- Assert reset mid-pump with 1 word buffered -> no ioctl_wr follows; all outputs return to their reset values on the next clk_sys edge.

Source files
------------

// File: rtl/data_io_pkg.sv
// rtl/data_io_pkg.sv - command codes, SPI engine states and CRC helper for data_io_sync
package data_io_pkg;

   localparam logic [7:0] CMD_ACK      = 8'h00;
   localparam logic [7:0] CMD_READ     = 8'h10;
   localparam logic [7:0] CMD_CONF     = 8'h14;
   localparam logic [7:0] CMD_STATUS   = 8'h15;
   localparam logic [7:0] CMD_INDEX    = 8'h55;
   localparam logic [7:0] CMD_PUMP     = 8'h61;
   localparam logic [7:0] CMD_PUMP_END = 8'h62;
   localparam logic [7:0] CMD_CRC      = 8'h63;
   localparam logic [7:0] ACK_BYTE     = 8'h4B;

   typedef enum logic [1:0] {IDLE, CMD, PAYLOAD} spi_state_t;

   // CRC-16/CCITT, one byte, MSB first
   function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
      logic [15:0] c;
      c = crc ^ {data, 8'h00};
      for (int i = 0; i < 8; i++) begin
         c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
      end
      return c;
   endfunction

endpackage

// File: rtl/data_io_if.sv
// rtl/data_io_if.sv - ioctl download bus between data_io_sync and the core
interface data_io_if #(
   parameter int AW = 25,
   parameter int DW = 8
);
   logic          ioctl_wait;
   logic          ioctl_download;
   logic [7:0]    ioctl_index;
   logic          ioctl_wr;
   logic [AW-1:0] ioctl_addr;
   logic [DW-1:0] ioctl_dout;
   logic          ioctl_overflow;

   modport master (
      input  ioctl_wait,
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_overflow
   );

   modport slave (
      output ioctl_wait,
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_overflow
   );
endinterface

// File: rtl/data_io_fifo.sv
// rtl/data_io_fifo.sv - synchronous FIFO for packed download words (address + data)
module data_io_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk_sys,
   input  logic         reset,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] pop_data,
   output logic         full,
   output logic         empty
);
   localparam int PW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [PW:0]  wr_ptr;
   logic [PW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   // Extra pointer bit tells full from empty when the indices coincide
   assign empty    = (wr_ptr == rd_ptr);
   assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
   assign pop_data = mem[rd_ptr[PW-1:0]];
   assign do_pop   = pop && !empty;
   assign do_push  = push && (!full || do_pop);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge clk_sys) begin
      if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
   end
endmodule

// File: rtl/data_io_sync.sv
// rtl/data_io_sync.sv - single-clock ARM-to-FPGA SPI command link with packed download FIFO
// Optional DATA_IO_CRC_EN adds ioctl_crc and command 0x63.
module data_io_sync #(
   parameter int  STRLEN       = 0,
   parameter int  DW           = 8,
   parameter int  AW           = 25,
   parameter int  FIFO_DEPTH   = 4,
   parameter int  STATUS_BYTES = 4,
   localparam int CONF_W       = (STRLEN > 0) ? 8*STRLEN : 8
) (
   input  logic                      clk_sys,
   input  logic                      reset,
   input  logic                      SPI_SCK,
   input  logic                      SPI_SS2,
   input  logic                      SPI_DI,
   output wire                       SPI_DO,
   input  logic [7:0]                data_in,
   input  logic [CONF_W-1:0]         conf_str,
   output logic [8*STATUS_BYTES-1:0] status,
`ifdef DATA_IO_CRC_EN
   output logic [15:0]               ioctl_crc,
`endif
   data_io_if.master                 io
);
   import data_io_pkg::*;

   localparam int NB = DW/8;

   logic [2:0]    sck_sync, ss_sync, di_sync;
   logic          sck_prev;
   logic          sck, ss_n, di, sck_rise, sck_fall;
   spi_state_t    state_q, state_d;
   logic [2:0]    bit_cnt;
   logic [6:0]    shift_q;
   logic [7:0]    tx_q, cmd_q, rx_byte, reply, conf_byte;
   logic [31:0]   byte_cnt;
   logic          byte_done, cmd_done, pay_done;
   logic          pump_start, pump_byte, pump_end, end_pending;
   logic [DW-1:0] pack_buf, word_next;
   logic [2:0]    pack_cnt;
   logic [AW-1:0] word_addr;
   logic          push, pop, full, empty;
   logic [AW+DW-1:0] push_data, pop_data;
   logic          unused_conf;
`ifdef DATA_IO_CRC_EN
   logic [15:0]   crc_q;
   assign ioctl_crc = crc_q;
`endif

   assign unused_conf = ^conf_str;

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         sck_sync <= '0;
         ss_sync  <= '1;
         di_sync  <= '0;
         sck_prev <= 1'b0;
      end else begin
         sck_sync <= {sck_sync[1:0], SPI_SCK};
         ss_sync  <= {ss_sync[1:0], SPI_SS2};
         di_sync  <= {di_sync[1:0], SPI_DI};
         sck_prev <= sck_sync[2];
      end
   end

   assign sck       = sck_sync[2];
   assign ss_n      = ss_sync[2];
   assign di        = di_sync[2];
   assign sck_rise  = sck && !sck_prev;
   assign sck_fall  = !sck && sck_prev;
   assign rx_byte   = {shift_q, di};
   assign byte_done = sck_rise && (bit_cnt == 3'd7) && (state_q != IDLE) && !ss_n;
   assign cmd_done  = byte_done && (state_q == CMD);
   assign pay_done  = byte_done && (state_q == PAYLOAD);
   assign SPI_DO    = (state_q == IDLE) ? 1'bz : tx_q[7];

   always_comb begin
      state_d = state_q;
      if (ss_n) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE:    state_d = CMD;
            CMD:     if (byte_done) state_d = PAYLOAD;
            default: state_d = state_q;
         endcase
      end
   end

   // Reply for the byte that starts at the next falling SCK edge
   always_comb begin
      conf_byte = 8'h00;
      for (int i = 0; i < STRLEN; i++) begin
         if (byte_cnt == 32'(i)) conf_byte = conf_str[8*(STRLEN-i)-1 -: 8];
      end
      case (cmd_q)
         CMD_ACK:  reply = ACK_BYTE;
         CMD_READ: reply = data_in;
         CMD_CONF: reply = conf_byte;
`ifdef DATA_IO_CRC_EN
         CMD_CRC:  reply = (byte_cnt == 32'd0) ? crc_q[15:8] :
                           (byte_cnt == 32'd1) ? crc_q[7:0] : 8'h00;
`else
         CMD_CRC:  reply = 8'h00;
`endif
         default:  reply = 8'h00;
      endcase
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q  <= IDLE;
         bit_cnt  <= '0;
         shift_q  <= '0;
         tx_q     <= '0;
         cmd_q    <= '0;
         byte_cnt <= '0;
      end else begin
         state_q <= state_d;
         if (state_d == IDLE) begin
            bit_cnt  <= '0;
            byte_cnt <= '0;
            tx_q     <= 8'h00;
         end else if (state_q != IDLE) begin
            if (sck_rise) begin
               shift_q <= rx_byte[6:0];
               bit_cnt <= bit_cnt + 3'd1;
            end
            if (cmd_done) cmd_q <= rx_byte;
            if (pay_done && byte_cnt != '1) byte_cnt <= byte_cnt + 32'd1;
            if (sck_fall) tx_q <= (bit_cnt == 3'd0) ? reply : {tx_q[6:0], 1'b0};
         end
      end
   end

   // Packer: a word's first byte clears the rest, so a partial word is already zero-padded
   always_comb begin
      word_next = (pack_cnt == 3'd0) ? '0 : pack_buf;
      for (int i = 0; i < NB; i++) begin
         if (pack_cnt == 3'(i)) word_next[8*i +: 8] = rx_byte;
      end
      pump_start = cmd_done && (rx_byte == CMD_PUMP) && !io.ioctl_download;
      pump_byte  = pay_done && (cmd_q == CMD_PUMP);
      pump_end   = cmd_done && (rx_byte == CMD_PUMP_END) && io.ioctl_download && (pack_cnt != 3'd0);
      push       = (pump_byte && (pack_cnt == 3'(NB-1))) || pump_end;
      push_data  = {word_addr, pump_end ? pack_buf : word_next};
      pop        = !empty && !io.ioctl_wait;
   end

   data_io_fifo #(.W(AW+DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_sys   (clk_sys),
      .reset     (reset),
      .push      (push),
      .push_data (push_data),
      .pop       (pop),
      .pop_data  (pop_data),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         io.ioctl_download <= 1'b0;
         io.ioctl_index    <= '0;
         io.ioctl_wr       <= 1'b0;
         io.ioctl_addr     <= '0;
         io.ioctl_dout     <= '0;
         io.ioctl_overflow <= 1'b0;
         status            <= '0;
         end_pending       <= 1'b0;
         pack_cnt          <= '0;
         pack_buf          <= '0;
         word_addr         <= '0;
      end else begin
         io.ioctl_wr <= pop;
         if (pop) {io.ioctl_addr, io.ioctl_dout} <= pop_data;

         if (pay_done && cmd_q == CMD_INDEX) io.ioctl_index <= rx_byte;
         if (pay_done && cmd_q == CMD_STATUS) begin
            for (int i = 0; i < STATUS_BYTES; i++) begin
               if (byte_cnt == 32'(i)) status[8*(STATUS_BYTES-1-i) +: 8] <= rx_byte;
            end
         end

         if (cmd_done && rx_byte == CMD_PUMP) end_pending <= 1'b0;
         if (pump_start) begin
            io.ioctl_download <= 1'b1;
            io.ioctl_overflow <= 1'b0;
            pack_cnt          <= '0;
            pack_buf          <= '0;
            word_addr         <= '0;
         end

         if (pump_byte) begin
            pack_buf <= word_next;
            pack_cnt <= (pack_cnt == 3'(NB-1)) ? 3'd0 : pack_cnt + 3'd1;
         end
         if (pump_end) begin
            pack_buf <= '0;
            pack_cnt <= '0;
         end
         // Address advances even when the word is dropped
         if (push) word_addr <= word_addr + AW'(NB);
         if (push && full && !pop) io.ioctl_overflow <= 1'b1;

         if (cmd_done && rx_byte == CMD_PUMP_END && io.ioctl_download) begin
            end_pending <= 1'b1;
         end else if (end_pending && empty && !push) begin
            end_pending       <= 1'b0;
            io.ioctl_download <= 1'b0;
         end
      end
   end

`ifdef DATA_IO_CRC_EN
   always_ff @(posedge clk_sys) begin
      if (reset || pump_start) crc_q <= 16'hFFFF;
      else if (pump_byte)      crc_q <= crc16_byte(crc_q, rx_byte);
   end
`endif
endmodule
